// File: rtl/axil_regs_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
package axil_regs_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   localparam int unsigned CHK_ADDR_W = 64;

   // True when a byte address falls inside a window of window_bytes bytes.
   function automatic logic addr_in_range(input logic [CHK_ADDR_W-1:0] addr,
                                          input logic [CHK_ADDR_W-1:0] window_bytes);
      return addr < window_bytes;
   endfunction

endpackage

// File: rtl/axil_regs_mem.sv
// Word storage with per-byte write enables, combinational read and async clear.
module axil_regs_mem
   import axil_regs_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 256,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     wr_be,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [8*N-1:0]   wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [8*N-1:0]   rd_data_c
);

   logic [8*N-1:0] mem_q [DEPTH];
   logic [8*N-1:0] mem_d [DEPTH];

   // Merge enabled bytes of the write word into the addressed entry.
   always_comb begin
      mem_d = mem_q;
      for (int unsigned b = 0; b < N; b++) begin
         if (wr_be[b]) begin
            mem_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   // Storage register; reset clears every word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data_c = mem_q[rd_idx];

endmodule

// File: rtl/axil_regs_slave.sv
// AXI4-Lite slave register bank: DEPTH words of N bytes, SLVERR outside the window.
// Optional build macro AXIL_REGS_PROT_EN refuses accesses with PROT[0]=0.
module axil_regs_slave
   import axil_regs_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic [2:0]        AWPROT,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [8*N-1:0]    WDATA,
   input  logic [N-1:0]      WSTRB,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic [2:0]        ARPROT,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [8*N-1:0]    RDATA,
   output logic [1:0]        RRESP,
   output logic              RVALID,
   input  logic              RREADY
);

   localparam int unsigned DW    = 8 * N;
   localparam int unsigned OFF_W = $clog2(N);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [CHK_ADDR_W-1:0] WIN_BYTES = CHK_ADDR_W'(DEPTH * N);

   logic aw_prot_ok_c;
   logic ar_prot_ok_c;
   logic unused_prot_c;

`ifdef AXIL_REGS_PROT_EN
   assign aw_prot_ok_c  = AWPROT[0];
   assign ar_prot_ok_c  = ARPROT[0];
   assign unused_prot_c = ^{AWPROT[2:1], ARPROT[2:1]};
`else
   assign aw_prot_ok_c  = 1'b1;
   assign ar_prot_ok_c  = 1'b1;
   assign unused_prot_c = ^{AWPROT, ARPROT};
`endif

   logic             aw_rdy_q, aw_rdy_d, aw_held_q, aw_held_d, aw_ok_q, aw_ok_d;
   logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
   logic             w_rdy_q, w_rdy_d, w_held_q, w_held_d;
   logic [DW-1:0]    w_data_q, w_data_d;
   logic [N-1:0]     w_strb_q, w_strb_d;
   logic             b_valid_q, b_valid_d;
   resp_t            b_resp_q, b_resp_d;
   logic             ar_rdy_q, ar_rdy_d, r_valid_q, r_valid_d;
   resp_t            r_resp_q, r_resp_d;
   logic [DW-1:0]    r_data_q, r_data_d;
   logic [N-1:0]     mem_be_c;
   logic [DW-1:0]    mem_rd_c;
   logic             ar_ok_c;

   // Write path: independent AW/W capture, commit once both are held, hold B until accepted.
   always_comb begin
      aw_held_d = aw_held_q;
      aw_ok_d   = aw_ok_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      b_valid_d = b_valid_q;
      b_resp_d  = b_resp_q;
      mem_be_c  = '0;
      if (AWVALID && aw_rdy_q) begin
         aw_held_d = 1'b1;
         aw_ok_d   = addr_in_range(CHK_ADDR_W'(AWADDR), WIN_BYTES) && aw_prot_ok_c;
         aw_idx_d  = AWADDR[OFF_W +: IDX_W];
      end
      if (WVALID && w_rdy_q) begin
         w_held_d = 1'b1;
         w_data_d = WDATA;
         w_strb_d = WSTRB;
      end
      if (aw_held_q && w_held_q) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         b_valid_d = 1'b1;
         b_resp_d  = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
         if (aw_ok_q) begin
            mem_be_c = w_strb_q;
         end
      end else if (b_valid_q && BREADY) begin
         b_valid_d = 1'b0;
      end
      aw_rdy_d = !(aw_held_d || b_valid_d);
      w_rdy_d  = !(w_held_d || b_valid_d);
   end

   // Read path: sample storage on AR acceptance, hold R until accepted.
   always_comb begin
      ar_ok_c   = addr_in_range(CHK_ADDR_W'(ARADDR), WIN_BYTES) && ar_prot_ok_c;
      r_valid_d = r_valid_q;
      r_resp_d  = r_resp_q;
      r_data_d  = r_data_q;
      if (ARVALID && ar_rdy_q) begin
         r_valid_d = 1'b1;
         r_resp_d  = ar_ok_c ? RESP_OKAY : RESP_SLVERR;
         r_data_d  = ar_ok_c ? mem_rd_c : '0;
      end else if (r_valid_q && RREADY) begin
         r_valid_d = 1'b0;
      end
      ar_rdy_d = !r_valid_d;
   end

   // Channel state registers.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_rdy_q  <= 1'b0;
         aw_held_q <= 1'b0;
         aw_ok_q   <= 1'b0;
         aw_idx_q  <= '0;
         w_rdy_q   <= 1'b0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_q <= 1'b0;
         b_resp_q  <= RESP_OKAY;
         ar_rdy_q  <= 1'b0;
         r_valid_q <= 1'b0;
         r_resp_q  <= RESP_OKAY;
         r_data_q  <= '0;
      end else begin
         aw_rdy_q  <= aw_rdy_d;
         aw_held_q <= aw_held_d;
         aw_ok_q   <= aw_ok_d;
         aw_idx_q  <= aw_idx_d;
         w_rdy_q   <= w_rdy_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         b_valid_q <= b_valid_d;
         b_resp_q  <= b_resp_d;
         ar_rdy_q  <= ar_rdy_d;
         r_valid_q <= r_valid_d;
         r_resp_q  <= r_resp_d;
         r_data_q  <= r_data_d;
      end
   end

   axil_regs_mem #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (ACLK),
      .rst_n     (ARESETn),
      .wr_be     (mem_be_c),
      .wr_idx    (aw_idx_q),
      .wr_data   (w_data_q),
      .rd_idx    (ARADDR[OFF_W +: IDX_W]),
      .rd_data_c (mem_rd_c)
   );

   assign AWREADY = aw_rdy_q;
   assign WREADY  = w_rdy_q;
   assign BVALID  = b_valid_q;
   assign BRESP   = b_resp_q;
   assign ARREADY = ar_rdy_q;
   assign RVALID  = r_valid_q;
   assign RRESP   = r_resp_q;
   assign RDATA   = r_data_q;

endmodule

// File: tb/tb_axil_regs_slave.sv
// Bench for axil_regs_slave: vector table plus scoreboarded multi-cycle sequences.
module tb_axil_regs_slave;
   import axil_regs_pkg::*;

   localparam int unsigned N      = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DEPTH  = 256;

`ifdef AXIL_REGS_PROT_EN
   localparam logic [2:0] PROT_OK = 3'b001;
`else
   localparam logic [2:0] PROT_OK = 3'b000;
`endif

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [2:0]  AWPROT, ARPROT;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;

   axil_regs_slave #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      resp_t       resp;
   } vec_t;

   typedef struct {
      resp_t       resp;
      logic [31:0] data;
   } rexp_t;

   int    n_checks = 0;
   int    n_pass   = 0;
   resp_t b_exp_q[$];
   rexp_t r_exp_q[$];
   vec_t  vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard: compare each B/R response at its handshake.
   always @(negedge ACLK) begin : mon
      resp_t be;
      rexp_t re;
      if (ARESETn && BVALID && BREADY) begin
         if (b_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected: got BRESP 0x%0h expected no response", BRESP);
         end else begin
            be = b_exp_q.pop_front();
            chk("sb_bresp", 64'(BRESP), 64'(be));
         end
      end
      if (ARESETn && RVALID && RREADY) begin
         if (r_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL r_unexpected: got RDATA 0x%0h expected no response", RDATA);
         end else begin
            re = r_exp_q.pop_front();
            chk("sb_rresp", 64'(RRESP), 64'(re.resp));
            chk("sb_rdata", 64'(RDATA), 64'(re.data));
         end
      end
   end

   task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
      int n = 0;
      AWADDR = a; AWPROT = p; AWVALID = 1'b1;
      @(negedge ACLK);
      while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
      chk("aw_accept", 64'(AWREADY), 64'd1);
      @(posedge ACLK); #1 AWVALID = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      WDATA = d; WSTRB = s; WVALID = 1'b1;
      @(negedge ACLK);
      while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
      chk("w_accept", 64'(WREADY), 64'd1);
      @(posedge ACLK); #1 WVALID = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
      int n = 0;
      ARADDR = a; ARPROT = p; ARVALID = 1'b1;
      @(negedge ACLK);
      while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
      chk("ar_accept", 64'(ARREADY), 64'd1);
      @(posedge ACLK); #1 ARVALID = 1'b0;
   endtask

   // Wait for BVALID, hold BREADY low for 'hold' cycles checking stability, then accept.
   task automatic recv_b(input int hold, input resp_t e);
      int n = 0;
      @(negedge ACLK);
      while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
      chk("b_wait", 64'(BVALID), 64'd1);
      repeat (hold) begin
         @(negedge ACLK);
         chk("b_hold_valid", 64'(BVALID), 64'd1);
         chk("b_hold_resp", 64'(BRESP), 64'(e));
         chk("b_hold_awready", 64'(AWREADY), 64'd0);
         chk("b_hold_wready", 64'(WREADY), 64'd0);
      end
      @(posedge ACLK); #1 BREADY = 1'b1;
      @(posedge ACLK); #1 BREADY = 1'b0;
   endtask

   task automatic recv_r(input int hold, input resp_t e, input logic [31:0] d);
      int n = 0;
      @(negedge ACLK);
      while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
      chk("r_wait", 64'(RVALID), 64'd1);
      repeat (hold) begin
         @(negedge ACLK);
         chk("r_hold_valid", 64'(RVALID), 64'd1);
         chk("r_hold_resp", 64'(RRESP), 64'(e));
         chk("r_hold_data", 64'(RDATA), 64'(d));
         chk("r_hold_arready", 64'(ARREADY), 64'd0);
      end
      @(posedge ACLK); #1 RREADY = 1'b1;
      @(posedge ACLK); #1 RREADY = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, input resp_t e);
      b_exp_q.push_back(e);
      fork
         send_aw(a, p);
         send_w(d, s);
      join
      recv_b(0, e);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [2:0] p, input resp_t e,
                          input logic [31:0] d);
      r_exp_q.push_back('{e, d});
      send_ar(a, p);
      recv_r(0, e, d);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      ARESETn = 1'b0;
      AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;

      vecs[0]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1011, RESP_OKAY};
      vecs[1]  = '{1'b0, 32'h0000_0100, 32'h1200_5678, 4'b0000, RESP_OKAY};
      vecs[2]  = '{1'b1, 32'h1234_5678, 32'h0000_ABCD, 4'b1111, RESP_SLVERR};
      vecs[3]  = '{1'b0, 32'h1234_5678, 32'h0000_0000, 4'b0000, RESP_SLVERR};
      vecs[4]  = '{1'b1, 32'h0000_03FC, 32'hDEAD_BEEF, 4'b1111, RESP_OKAY};
      vecs[5]  = '{1'b0, 32'h0000_03FC, 32'hDEAD_BEEF, 4'b0000, RESP_OKAY};
      vecs[6]  = '{1'b1, 32'h0000_0400, 32'h5555_5555, 4'b1111, RESP_SLVERR};
      vecs[7]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'b0000, RESP_SLVERR};
      vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, RESP_OKAY};
      vecs[9]  = '{1'b1, 32'h0000_0103, 32'hAABB_CCDD, 4'b0100, RESP_OKAY};
      vecs[10] = '{1'b0, 32'h0000_0101, 32'h12BB_5678, 4'b0000, RESP_OKAY};
      vecs[11] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0000, RESP_OKAY};
      vecs[12] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'b0000, RESP_OKAY};
      vecs[13] = '{1'b0, 32'h0000_0278, 32'h0000_0000, 4'b0000, RESP_OKAY};

      // Reset values, then ready from the first cycle after release.
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_awready", 64'(AWREADY), 64'd0);
      chk("rst_wready", 64'(WREADY), 64'd0);
      chk("rst_arready", 64'(ARREADY), 64'd0);
      #2 ARESETn = 1'b1;
      @(negedge ACLK);
      chk("post_rst_awready", 64'(AWREADY), 64'd1);
      chk("post_rst_wready", 64'(WREADY), 64'd1);
      chk("post_rst_arready", 64'(ARREADY), 64'd1);
      chk("post_rst_bvalid", 64'(BVALID), 64'd0);
      chk("post_rst_rvalid", 64'(RVALID), 64'd0);
      chk("post_rst_bresp", 64'(BRESP), 64'd0);
      chk("post_rst_rresp", 64'(RRESP), 64'd0);
      chk("post_rst_rdata", 64'(RDATA), 64'd0);
      @(posedge ACLK); #1;

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, PROT_OK, vecs[i].resp);
         else            do_read(vecs[i].addr, PROT_OK, vecs[i].resp, vecs[i].data);
      end

      // W three cycles ahead of AW, then a slow BREADY.
      b_exp_q.push_back(RESP_OKAY);
      send_w(32'hCAFE_F00D, 4'hF);
      repeat (3) begin
         @(negedge ACLK);
         chk("early_w_wready", 64'(WREADY), 64'd0);
         chk("early_w_awready", 64'(AWREADY), 64'd1);
         chk("early_w_bvalid", 64'(BVALID), 64'd0);
      end
      @(posedge ACLK); #1;
      send_aw(32'h0000_0008, PROT_OK);
      recv_b(5, RESP_OKAY);
      @(negedge ACLK);
      chk("b_done_awready", 64'(AWREADY), 64'd1);
      chk("b_done_wready", 64'(WREADY), 64'd1);
      chk("b_done_bvalid", 64'(BVALID), 64'd0);
      @(posedge ACLK); #1;
      do_read(32'h0000_0008, PROT_OK, RESP_OKAY, 32'hCAFE_F00D);

      // Stalled read while a write to another word completes.
      do_write(32'h0000_0010, 32'h1111_2222, 4'hF, PROT_OK, RESP_OKAY);
      r_exp_q.push_back('{RESP_OKAY, 32'h1111_2222});
      send_ar(32'h0000_0010, PROT_OK);
      fork
         recv_r(4, RESP_OKAY, 32'h1111_2222);
         begin
            b_exp_q.push_back(RESP_OKAY);
            fork
               send_aw(32'h0000_0014, PROT_OK);
               send_w(32'h3333_4444, 4'hF);
            join
            recv_b(0, RESP_OKAY);
         end
      join
      do_read(32'h0000_0014, PROT_OK, RESP_OKAY, 32'h3333_4444);

      // Read sampling the word on the same edge the write commits sees old data.
      do_write(32'h0000_0020, 32'hA1A1_A1A1, 4'hF, PROT_OK, RESP_OKAY);
      b_exp_q.push_back(RESP_OKAY);
      r_exp_q.push_back('{RESP_OKAY, 32'hA1A1_A1A1});
      fork
         begin
            fork
               send_aw(32'h0000_0020, PROT_OK);
               send_w(32'hB2B2_B2B2, 4'hF);
            join
            recv_b(0, RESP_OKAY);
         end
         begin
            @(posedge ACLK); #1;
            send_ar(32'h0000_0020, PROT_OK);
            recv_r(0, RESP_OKAY, 32'hA1A1_A1A1);
         end
      join
      do_read(32'h0000_0020, PROT_OK, RESP_OKAY, 32'hB2B2_B2B2);

`ifdef AXIL_REGS_PROT_EN
      do_write(32'h0000_0100, 32'h5A5A_5A5A, 4'hF, 3'b000, RESP_SLVERR);
      do_read(32'h0000_0100, 3'b001, RESP_OKAY, 32'h12BB_5678);
      do_write(32'h0000_0100, 32'h5A5A_5A5A, 4'hF, 3'b001, RESP_OKAY);
      do_read(32'h0000_0100, 3'b001, RESP_OKAY, 32'h5A5A_5A5A);
      do_read(32'h0000_0100, 3'b000, RESP_SLVERR, 32'h0000_0000);
`endif

      // Write latency, then reset while BVALID is high.
      fork
         send_aw(32'h0000_0100, PROT_OK);
         send_w(32'hFFFF_FFFF, 4'hF);
      join
      @(negedge ACLK);
      chk("lat_bvalid_early", 64'(BVALID), 64'd0);
      @(negedge ACLK);
      chk("lat_bvalid", 64'(BVALID), 64'd1);
      #2 ARESETn = 1'b0;
      #1;
      chk("async_rst_bvalid", 64'(BVALID), 64'd0);
      chk("async_rst_awready", 64'(AWREADY), 64'd0);
      chk("async_rst_arready", 64'(ARREADY), 64'd0);
      @(negedge ACLK);
      #2 ARESETn = 1'b1;
      @(posedge ACLK); #1;
      r_exp_q.push_back('{RESP_OKAY, 32'h0000_0000});
      send_ar(32'h0000_0100, PROT_OK);
      @(negedge ACLK);
      chk("lat_rvalid", 64'(RVALID), 64'd1);
      recv_r(0, RESP_OKAY, 32'h0000_0000);
      do_read(32'h0000_03FC, PROT_OK, RESP_OKAY, 32'h0000_0000);
      do_read(32'h0000_0008, PROT_OK, RESP_OKAY, 32'h0000_0000);

      @(negedge ACLK);
      chk("sb_b_drained", 64'(b_exp_q.size()), 64'd0);
      chk("sb_r_drained", 64'(r_exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
